// File: rtl/demo_pkg.sv
// Shared constants for the logic-analyzer demo stimulus generator:
// pattern mode codes and analyzer-reset FSM state encoding.
package demo_pkg;

   localparam logic [1:0] MODE_TOGGLE = 2'd0;
   localparam logic [1:0] MODE_WALK   = 2'd1;
   localparam logic [1:0] MODE_LFSR   = 2'd2;
   localparam logic [1:0] MODE_COUNT  = 2'd3;

   localparam logic [1:0] ST_ARM   = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/demo_stim_gen_bit_rise_tick.sv
// Rising-edge detector on a bit: registers d and pulses tick for one
// cycle when d is high and its registered copy is low. Ports: clk, rst, d, tick.
module bit_rise_tick (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic tick
);

   logic q;

   always_ff @(posedge clk) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

   assign tick = d & ~q;

endmodule

// File: rtl/demo_stim_gen.sv
// Stimulus/housekeeping generator for the analyzer demos: analyzer reset
// pulse, free-running counter, prescaled LEDs and a mode-selectable pattern.
// Ports: clk, rst, mode, hold in; la_rst_l, por_done, count, tick, led,
// pattern, la_data out.
module demo_stim_gen
   import demo_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                CNT_W        = 17,
   parameter int                PRESCALE_BIT = 16,
   parameter int                PAT_BIT      = 2,
   parameter int                LED_W        = 5,
   parameter int                LED_LSB      = 3,
   parameter int                PROBE_W      = 8,
   parameter int                POR_LOW      = 1,
   parameter logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                mode,
   input  logic                      hold,
   output logic                      la_rst_l,
   output logic                      por_done,
   output logic [CNT_W-1:0]          count,
   output logic                      tick,
   output logic [LED_W-1:0]          led,
   output logic [DATA_W-1:0]         pattern,
   output logic [DATA_W+PROBE_W-1:0] la_data
);

   localparam int SW = LED_LSB + LED_W;
   localparam int PW = (POR_LOW > 1) ? $clog2(POR_LOW) : 1;

   logic [SW-1:0] slow;
   logic [1:0]    mode_q;
   logic [1:0]    state;
   logic [PW-1:0] pcnt;
   logic          ptick;

   function automatic logic [DATA_W-1:0] pat_seed(input logic [1:0] m);
      logic [DATA_W-1:0] s;
      s = '0;
      unique case (m)
         MODE_TOGGLE: s = {(DATA_W/2){2'b10}};
         MODE_WALK:   s = DATA_W'(1);
         MODE_LFSR:   s = DATA_W'(1);
         MODE_COUNT:  s = '0;
         default:     s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] pat_next(
      input logic [1:0]        m,
      input logic [DATA_W-1:0] p
   );
      logic [DATA_W-1:0] n;
      n = p;
      unique case (m)
         MODE_TOGGLE: n = ~p;
         MODE_WALK:   n = {p[DATA_W-2:0], p[DATA_W-1]};
         MODE_LFSR: begin
            // all-zero is a lock-up state for the LFSR; restart it
            if (p == '0) n = DATA_W'(1);
            else         n = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
         end
         MODE_COUNT:  n = p + DATA_W'(1);
         default:     n = p;
      endcase
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= count + CNT_W'(1);
   end

   bit_rise_tick u_tick (
      .clk  (clk),
      .rst  (rst),
      .d    (count[PRESCALE_BIT]),
      .tick (tick)
   );

   bit_rise_tick u_ptick (
      .clk  (clk),
      .rst  (rst),
      .d    (count[PAT_BIT]),
      .tick (ptick)
   );

   always_ff @(posedge clk) begin
      if (rst)       slow <= '0;
      else if (tick) slow <= slow + SW'(1);
   end

   assign led = slow[LED_LSB +: LED_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_ARM;
         pcnt     <= '0;
         la_rst_l <= 1'b1;
         por_done <= 1'b0;
      end else begin
         unique case (1'b1)
            state == ST_ARM: begin
               state    <= ST_PULSE;
               pcnt     <= '0;
               la_rst_l <= 1'b0;
            end
            state == ST_PULSE: begin
               if (pcnt == PW'(POR_LOW - 1)) begin
                  state    <= ST_DONE;
                  la_rst_l <= 1'b1;
                  por_done <= 1'b1;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            state == ST_DONE: begin
               la_rst_l <= 1'b1;
               por_done <= 1'b1;
            end
            default: begin
               state    <= ST_ARM;
               la_rst_l <= 1'b1;
               por_done <= 1'b0;
            end
         endcase
      end
   end

   // a mode change reseeds even under hold and wins over a coincident advance
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_TOGGLE;
         pattern <= pat_seed(MODE_TOGGLE);
      end else begin
         mode_q <= mode;
         if (mode != mode_q)
            pattern <= pat_seed(mode);
         else if (ptick & ~hold)
            pattern <= pat_next(mode_q, pattern);
      end
   end

   assign la_data = {pattern, count[PROBE_W:1]};

endmodule

// File: tb/tb_demo_stim_gen.sv
// Self-checking bench for demo_stim_gen with a cycle model feeding a
// scoreboard queue; DUT built with CNT_W=10, PRESCALE_BIT=4, POR_LOW=3.
module tb_demo_stim_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic        hold = 1'b0;
   logic        la_rst_l;
   logic        por_done;
   logic [9:0]  count;
   logic        tick;
   logic [4:0]  led;
   logic [7:0]  pattern;
   logic [15:0] la_data;

   demo_stim_gen #(
      .CNT_W        (10),
      .PRESCALE_BIT (4),
      .POR_LOW      (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .hold     (hold),
      .la_rst_l (la_rst_l),
      .por_done (por_done),
      .count    (count),
      .tick     (tick),
      .led      (led),
      .pattern  (pattern),
      .la_data  (la_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  cnt;
      logic        tk;
      logic [4:0]  led;
      logic [7:0]  pat;
      logic [15:0] lad;
      logic        lrl;
      logic        pd;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   int         m_cnt = 0;
   int         m_k = 0;
   logic [7:0] m_pat = 8'hAA;
   logic [7:0] m_slow = 8'h00;
   logic [1:0] m_modeq = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_seed(input logic [1:0] m);
      if (m == 2'd0) return 8'hAA;
      if (m == 2'd3) return 8'h00;
      return 8'h01;
   endfunction

   function automatic logic [7:0] m_adv(input logic [1:0] m,
                                        input logic [7:0] p);
      logic [7:0] r;
      case (m)
         2'd0: r = p ^ 8'hFF;
         2'd1: r = (p << 1) | (p >> 7);
         2'd2: begin
            if (p == 8'h00) r = 8'h01;
            else if (p[0])  r = (p >> 1) ^ 8'hB8;
            else            r = p >> 1;
         end
         default: r = p + 8'd1;
      endcase
      return r;
   endfunction

   task automatic step(input logic r, input logic [1:0] md, input logic h);
      exp_t e;
      exp_t o;
      logic tk_now;
      logic pt_now;
      @(negedge clk);
      rst  = r;
      mode = md;
      hold = h;
      tk_now = (m_cnt % 32) == 16;
      pt_now = (m_cnt % 8) == 4;
      if (r) begin
         m_cnt   = 0;
         m_k     = 0;
         m_slow  = 8'h00;
         m_pat   = 8'hAA;
         m_modeq = 2'd0;
      end else begin
         if (tk_now) m_slow = m_slow + 8'd1;
         if (md != m_modeq)      m_pat = m_seed(md);
         else if (pt_now && !h)  m_pat = m_adv(md, m_pat);
         m_modeq = md;
         m_cnt   = (m_cnt + 1) % 1024;
         m_k++;
      end
      e.cnt = 10'(m_cnt);
      e.tk  = (m_cnt % 32) == 16;
      e.led = m_slow[7:3];
      e.pat = m_pat;
      e.lad = {m_pat, e.cnt[8:1]};
      e.lrl = !(m_k >= 1 && m_k <= 3);
      e.pd  = m_k >= 4;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("count",    32'(count),    32'(o.cnt));
      chk("tick",     32'(tick),     32'(o.tk));
      chk("led",      32'(led),      32'(o.led));
      chk("pattern",  32'(pattern),  32'(o.pat));
      chk("la_data",  32'(la_data),  32'(o.lad));
      chk("la_rst_l", 32'(la_rst_l), 32'(o.lrl));
      chk("por_done", 32'(por_done), 32'(o.pd));
   endtask

   task automatic run_pticks(input int n, input logic [1:0] md,
                             input logic h);
      int seen;
      seen = 0;
      for (int i = 0; i < n * 8 + 8 && seen < n; i++) begin
         if ((m_cnt % 8) == 4) seen++;
         step(1'b0, md, h);
      end
   endtask

   task automatic run(input int n, input logic [1:0] md, input logic h);
      for (int i = 0; i < n; i++) step(1'b0, md, h);
   endtask

   logic [7:0] walk;

   initial begin
      for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 1'b0);
      chk("rst_pattern", 32'(pattern), 32'hAA);
      chk("rst_la_rst_l", 32'(la_rst_l), 32'd1);

      run(40, 2'd0, 1'b0);
      chk("done_after_run", 32'(por_done), 32'd1);

      step(1'b1, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b0);
      step(1'b1, 2'd0, 1'b0);
      chk("midpulse_rst", 32'(la_rst_l), 32'd1);
      run(12, 2'd0, 1'b0);

      run(1100, 2'd0, 1'b0);

      step(1'b0, 2'd1, 1'b0);
      chk("walk_seed", 32'(pattern), 32'h01);
      walk = 8'h01;
      for (int i = 0; i < 8; i++) begin
         run_pticks(1, 2'd1, 1'b0);
         walk = {walk[6:0], walk[7]};
         chk("walk_step", 32'(pattern), 32'(walk));
      end

      step(1'b0, 2'd2, 1'b0);
      chk("lfsr_seed", 32'(pattern), 32'h01);
      run_pticks(1, 2'd2, 1'b0);
      chk("lfsr_1", 32'(pattern), 32'hB8);
      run_pticks(1, 2'd2, 1'b0);
      chk("lfsr_2", 32'(pattern), 32'h5C);
      run_pticks(1, 2'd2, 1'b0);
      chk("lfsr_3", 32'(pattern), 32'h2E);

      step(1'b0, 2'd3, 1'b0);
      chk("count_seed", 32'(pattern), 32'h00);
      run_pticks(2, 2'd3, 1'b0);
      chk("count_2", 32'(pattern), 32'h02);
      run_pticks(3, 2'd3, 1'b1);
      chk("hold_frozen", 32'(pattern), 32'h02);
      run_pticks(1, 2'd3, 1'b0);
      chk("hold_resume", 32'(pattern), 32'h03);
      step(1'b0, 2'd0, 1'b1);
      chk("hold_seed", 32'(pattern), 32'hAA);
      run(10, 2'd0, 1'b0);

      for (int i = 0; i < 16 && (m_cnt % 8) != 4; i++)
         step(1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd1, 1'b0);
      chk("ptick_mode_seed", 32'(pattern), 32'h01);
      run(20, 2'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
